// File: rtl/edge_period_meter.sv
// rtl/edge_period_meter.sv - measures period and high time of an asynchronous signal in clk cycles
// One measurement per start: synchronise sig_in, wait for a rise, count to the next rise.
module edge_period_meter #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       hi_cap_q, hi_cap_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic                   fall_seen_q, fall_seen_d;
   logic                   sync_out, rise, fall;

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise     = sync_out & ~prev_q;
   assign fall     = ~sync_out & prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= sync_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hi_cap_q    <= '0;
         fall_seen_q <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_cap_q    <= hi_cap_d;
         fall_seen_q <= fall_seen_d;
         period_q    <= period_d;
         high_q      <= high_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_cap_d    = hi_cap_q;
      fall_seen_d = fall_seen_q;
      period_d    = period_q;
      high_d      = high_q;
      valid       = 1'b0;
      timeout     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT_RISE;
               cnt_d   = '0;
            end
         end
         WAIT_RISE: begin
            // a rise exactly at saturation still starts the measurement
            if (rise) begin
               state_d     = MEASURE;
               cnt_d       = CNT_ONE;
               fall_seen_d = 1'b0;
            end else if (cnt_q == CNT_MAX) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_d = cnt_q;
               high_d   = fall_seen_q ? hi_cap_q : cnt_q;
               valid    = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (fall && !fall_seen_q) begin
                  hi_cap_d    = cnt_q;
                  fall_seen_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign period    = period_q;
   assign high_time = high_q;

endmodule
